// File: rtl/multi_feature_norm_pkg.sv
// Shared widths and constants for the product-to-pixel normaliser.
// Build option: MULTI_FEATURE_NORM_ROUND_EN selects round-to-nearest.
package multi_feature_norm_pkg;

  localparam int IN_W_DEF       = 20;
  localparam int OUT_W_DEF      = 8;
  localparam int SH_W_DEF       = 4;
  localparam int INIT_SHIFT_DEF = IN_W_DEF - OUT_W_DEF;

  localparam logic [OUT_W_DEF-1:0] SAT_MAX = '1;

endpackage

// File: rtl/multi_feature_norm_if.sv
// Pixel stream bundle: line/frame valid plus data.
// Used for both the product input and the normalised output.
interface multi_feature_norm_if #(
  parameter int W = 20
) ();

  logic         h_aync;
  logic         v_aync;
  logic [W-1:0] data;

  modport master (
    output h_aync,
    output v_aync,
    output data
  );

  modport slave (
    input h_aync,
    input v_aync,
    input data
  );

endinterface

// File: rtl/multi_feature_norm_msb_detect.sv
// Leading-one detector: index of the highest set bit, 0 for zero.
// Purely combinational; sized for the product width.
module multi_feature_norm_msb_detect
  import multi_feature_norm_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int SH_W = SH_W_DEF
) (
  input  logic [IN_W-1:0] din,
  output logic [SH_W:0]   idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (din[i]) idx = (SH_W+1)'(i);
    end
  end

endmodule

// File: rtl/multi_feature_norm.sv
// Adaptive right-shift normaliser: 20-bit product -> 8-bit pixel.
// MULTI_FEATURE_NORM_ROUND_EN adds round-to-nearest before the shift.
module multi_feature_norm
  import multi_feature_norm_pkg::*;
#(
  parameter int IN_W       = IN_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int SH_W       = SH_W_DEF,
  parameter int INIT_SHIFT = INIT_SHIFT_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_h_aync,
  input  logic             i_v_aync,
  input  logic [IN_W-1:0]  i_data,
  output logic             o_h_aync,
  output logic             o_v_aync,
  output logic [OUT_W-1:0] o_data,
  output logic [SH_W-1:0]  o_shift
);

  logic            rh;
  logic            rv;
  logic            rv_d;
  logic [IN_W-1:0] rd;
  logic [IN_W-1:0] peak;
  logic [SH_W-1:0] shift;
  logic [SH_W:0]   peak_msb;
  logic [SH_W-1:0] shift_nxt;
  logic            valid;
  logic            fe;
  logic [IN_W:0]   pre;
  logic [IN_W:0]   shifted;
  logic [OUT_W-1:0] pix;

  assign valid = rh && rv;
  assign fe    = rv_d && !rv;

  multi_feature_norm_msb_detect #(
    .IN_W (IN_W),
    .SH_W (SH_W)
  ) u_msb (
    .din (peak),
    .idx (peak_msb)
  );

  // Keep OUT_W significant bits below the peak's leading one.
  always_comb begin
    shift_nxt = '0;
    if (int'(peak_msb) > OUT_W - 1)
      shift_nxt = SH_W'(int'(peak_msb) - (OUT_W - 1));
  end

`ifdef MULTI_FEATURE_NORM_ROUND_EN
  always_comb begin
    pre = {1'b0, rd};
    if (shift != '0)
      pre = {1'b0, rd} + ((IN_W+1)'(1) << (shift - 1'b1));
  end
`else
  assign pre = {1'b0, rd};
`endif

  assign shifted = pre >> shift;

  always_comb begin
    pix = shifted[OUT_W-1:0];
    if (|shifted[IN_W:OUT_W]) pix = SAT_MAX;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rh   <= 1'b0;
      rv   <= 1'b0;
      rv_d <= 1'b0;
      rd   <= '0;
    end else begin
      rh   <= i_h_aync;
      rv   <= i_v_aync;
      rv_d <= rv;
      rd   <= i_data;
    end
  end

  // Frame statistics: shift only moves on the v falling edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      peak  <= '0;
      shift <= SH_W'(INIT_SHIFT);
    end else if (fe) begin
      peak  <= '0;
      shift <= shift_nxt;
    end else if (valid && (rd > peak)) begin
      peak  <= rd;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_h_aync <= 1'b0;
      o_v_aync <= 1'b0;
      o_data   <= '0;
    end else begin
      o_h_aync <= rh;
      o_v_aync <= rv;
      o_data   <= valid ? pix : '0;
    end
  end

  assign o_shift = shift;

endmodule

// File: tb/tb_multi_feature_norm.sv
// Directed bench for multi_feature_norm.
// Expected values follow MULTI_FEATURE_NORM_ROUND_EN when defined.
module tb_multi_feature_norm;

  logic       clk;
  logic       rst_n;
  logic [3:0] shift;
  int         n_chk;
  int         n_pass;

`ifdef MULTI_FEATURE_NORM_ROUND_EN
  localparam int E_F1  = 16;
  localparam int E_384 = 2;
`else
  localparam int E_F1  = 15;
  localparam int E_384 = 1;
`endif

  multi_feature_norm_if #(.W(20)) in_if ();
  multi_feature_norm_if #(.W(8))  out_if ();

  multi_feature_norm dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_h_aync (in_if.h_aync),
    .i_v_aync (in_if.v_aync),
    .i_data   (in_if.data),
    .o_h_aync (out_if.h_aync),
    .o_v_aync (out_if.v_aync),
    .o_data   (out_if.data),
    .o_shift  (shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic h, input logic v,
                      input logic [19:0] d);
    in_if.h_aync = h;
    in_if.v_aync = v;
    in_if.data   = d;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs,
                     input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    in_if.h_aync = 1'b0;
    in_if.v_aync = 1'b0;
    in_if.data   = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_data", int'(out_if.data), 0);
    chk("rst_h", int'(out_if.h_aync), 0);
    chk("rst_v", int'(out_if.v_aync), 0);
    chk("rst_shift", int'(shift), 12);
    rst_n = 1'b1;

    // frame 1 at the reset shift
    step(0, 1, 0);
    step(1, 1, 65025);
    step(0, 1, 0);
    chk("f1_data", int'(out_if.data), E_F1);
    chk("f1_h", int'(out_if.h_aync), 1);
    chk("f1_shift", int'(shift), 12);
    step(0, 1, 0);
    chk("f1_idle", int'(out_if.data), 0);
    // single v-low cycle between frames
    step(0, 0, 0);

    // frame 2
    step(1, 1, 65025);
    step(1, 1, 300);
    chk("f2_65025", int'(out_if.data), 254);
    chk("f2_shift", int'(shift), 8);
    step(1, 1, 384);
    chk("f2_300", int'(out_if.data), 1);
    step(0, 1, 0);
    chk("f2_384", int'(out_if.data), E_384);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("f2_end_shift", int'(shift), 8);

    // v high, h never high
    step(0, 1, 65025);
    step(0, 1, 65025);
    chk("empty_d0", int'(out_if.data), 0);
    chk("empty_v", int'(out_if.v_aync), 1);
    step(0, 1, 65025);
    chk("empty_d1", int'(out_if.data), 0);
    step(0, 0, 0);
    chk("empty_d2", int'(out_if.data), 0);
    step(0, 0, 0);
    chk("empty_shift", int'(shift), 0);

    // shift 0: pass-through and saturation
    step(1, 1, 200);
    step(1, 1, 1000);
    chk("s0_200", int'(out_if.data), 200);
    step(0, 1, 0);
    chk("s0_sat", int'(out_if.data), 255);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("pk1000_shift", int'(shift), 2);

    // h high while v low: no output, no peak update
    step(1, 0, 65025);
    step(1, 0, 65025);
    chk("gap_data", int'(out_if.data), 0);
    chk("gap_h", int'(out_if.h_aync), 1);
    chk("gap_v", int'(out_if.v_aync), 0);
    step(1, 1, 100);
    chk("gap_data2", int'(out_if.data), 0);
    step(0, 1, 0);
    chk("s2_100", int'(out_if.data), 25);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("gap_peak_shift", int'(shift), 0);

    // reset in the middle of a frame
    step(1, 1, 65025);
    step(1, 1, 65025);
    chk("pre_rst_data", int'(out_if.data), 255);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_data", int'(out_if.data), 0);
    chk("mid_rst_h", int'(out_if.h_aync), 0);
    chk("mid_rst_v", int'(out_if.v_aync), 0);
    chk("mid_rst_shift", int'(shift), 12);
    in_if.h_aync = 1'b0;
    in_if.v_aync = 1'b0;
    in_if.data   = '0;
    @(negedge clk);
    rst_n = 1'b1;

    step(0, 1, 0);
    step(1, 1, 65025);
    step(0, 1, 0);
    chk("post_rst_data", int'(out_if.data), E_F1);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("post_rst_shift", int'(shift), 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
